// File: rtl/register_4bit_en_pkg.sv
// rtl/register_4bit_en_pkg.sv - shared constants and width check for the loadable register
package register_4bit_en_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_WIDTH     = 1;
    localparam int MAX_WIDTH     = 64;

    function automatic bit width_legal(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/register_4bit_en.sv
// rtl/register_4bit_en.sv - width-parameterised register with load enable and async active-high reset
module register_4bit_en
    import register_4bit_en_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $fatal(1, "register_4bit_en: WIDTH must be in 1..64");
    end

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             released_d;
    logic             released_q;

    // Enable is a data-path mux in front of the flops; the clock is never gated.
    always_comb begin
        q_d        = q_q;
        released_d = 1'b1;
        if (enable) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q        <= RESET_VALUE;
            released_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            released_q <= released_d;
        end
    end

    assign q = q_q;

    // Control inputs must be known once the first reset has been released.
    a_ctrl_known: assert property (@(posedge clk) released_q |-> !$isunknown({enable, reset}))
        else $error("register_4bit_en: X/Z on enable or reset");

endmodule

// File: tb/tb_register_4bit_en.sv
// tb/tb_register_4bit_en.sv - scoreboard bench for register_4bit_en at WIDTH 4, 1 and 16
module tb_register_4bit_en;

    localparam logic [15:0] RV16 = 16'hA5A5;

    typedef struct {
        string       tag;
        logic [3:0]  e4;
        logic [0:0]  e1;
        logic [15:0] e16;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  d4;
    logic [0:0]  d1;
    logic [15:0] d16;
    logic [3:0]  q4;
    logic [0:0]  q1;
    logic [15:0] q16;

    exp_t exp_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: what each register should hold, from the load/hold/reset rules.
    logic [3:0]  m4;
    logic [0:0]  m1;
    logic [15:0] m16;

    always #5 clk = ~clk;

    register_4bit_en u_w4 (
        .clk(clk), .reset(reset), .enable(enable), .d(d4), .q(q4)
    );

    register_4bit_en #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .enable(enable), .d(d1), .q(q1)
    );

    register_4bit_en #(.WIDTH(16), .RESET_VALUE(RV16)) u_w16 (
        .clk(clk), .reset(reset), .enable(enable), .d(d16), .q(q16)
    );

    task automatic push_and_sample(input string tag);
        exp_t e;
        e.tag = tag;
        e.e4  = m4;
        e.e1  = m1;
        e.e16 = m16;
        exp_q.push_back(e);
        #1;
        -> sample_ev;
        #0;
    endtask

    // Drive on the falling edge, let the model observe the rising edge, check 1 time unit later.
    task automatic cycle(input string tag, input logic r, input logic en,
                         input logic [3:0] v4, input logic [0:0] v1, input logic [15:0] v16);
        @(negedge clk);
        reset  = r;
        enable = en;
        d4     = v4;
        d1     = v1;
        d16    = v16;
        if (r) begin
            m4 = 4'h0; m1 = 1'b0; m16 = RV16;
        end
        @(posedge clk);
        if (reset) begin
            m4 = 4'h0; m1 = 1'b0; m16 = RV16;
        end else if (enable) begin
            m4 = d4; m1 = d1; m16 = d16;
        end
        push_and_sample(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        m4 = 4'h0; m1 = 1'b0; m16 = RV16;
        push_and_sample(tag);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL %s: got sample with empty scoreboard, required an expected entry", "scoreboard");
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (q4 === e.e4) n_pass++;
                else $display("FAIL %s w4: got %h required %h", e.tag, q4, e.e4);
                n_checks++;
                if (q1 === e.e1) n_pass++;
                else $display("FAIL %s w1: got %h required %h", e.tag, q1, e.e1);
                n_checks++;
                if (q16 === e.e16) n_pass++;
                else $display("FAIL %s w16: got %h required %h", e.tag, q16, e.e16);
            end
        end
    end

    initial begin : stimulus
        int waited;
        reset  = 1'b1;
        enable = 1'b0;
        d4     = 4'h0;
        d1     = 1'b0;
        d16    = 16'h0000;
        m4 = 4'h0; m1 = 1'b0; m16 = RV16;
        #3;
        push_and_sample("reset_no_edge");
        cycle("reset_held", 1'b1, 1'b0, 4'h0, 1'b0, 16'h0000);
        cycle("released_idle", 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000);

        cycle("load_1010", 1'b0, 1'b1, 4'b1010, 1'b1, 16'h1234);
        cycle("load_0101", 1'b0, 1'b1, 4'b0101, 1'b0, 16'h1234);
        for (int i = 0; i < 3; i++)
            cycle("hold_1111", 1'b0, 1'b0, 4'b1111, 1'b1, 16'hFFFF);

        async_reset("async_mid_cycle");
        cycle("reset_held_en", 1'b1, 1'b1, 4'b1111, 1'b1, 16'hFFFF);
        cycle("collision", 1'b1, 1'b1, 4'b0110, 1'b1, 16'h1234);
        cycle("load_after_release", 1'b0, 1'b1, 4'b0110, 1'b1, 16'h1234);
        cycle("hold_16", 1'b0, 1'b0, 4'b1001, 1'b0, 16'h0F0F);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                async_reset("rand_async");
            end
            cycle("random", ($urandom_range(0, 9) == 0), 1'($urandom),
                  4'($urandom), 1'($urandom), 16'($urandom));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: got %0d pending entries, required 0", "drain", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
